// File: rtl/oc8051_ifetch_if.sv
// Program ROM read port plus the fetch-to-decoder instruction channel.
// master = fetch unit, slave = ROM / decoder side.
interface oc8051_ifetch_if;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data1;
  logic [7:0]  rom_data2;
  logic [7:0]  rom_data3;
  logic        ea_int;

  // ins_* form a valid/ready channel: an instruction transfers on a rising edge
  // where ins_valid && ins_ready; while ins_valid=1 and ins_ready=0 every ins_*
  // payload field is held stable; ins_valid never depends on ins_ready.
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_op;
  logic [7:0]  ins_op1;
  logic [7:0]  ins_op2;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;

  modport master (
    output rom_addr,
    input  rom_data1, rom_data2, rom_data3, ea_int,
    output ins_valid, ins_op, ins_op1, ins_op2, ins_len, ins_pc,
    input  ins_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data1, rom_data2, rom_data3, ea_int,
    input  ins_valid, ins_op, ins_op1, ins_op2, ins_len, ins_pc,
    output ins_ready
  );
endinterface

// File: rtl/oc8051_ifetch.sv
// oc8051 instruction fetch: PC, ROM window capture, length decode, valid/ready hand-off.
// Optional external-ROM fault detection: define OC8051_IFETCH_EA_CHECK_EN.
module oc8051_ifetch #(
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           pc_in,
  input  logic                  pc_load,
  oc8051_ifetch_if.master       bus,
  output logic                  ext_fault,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
`ifdef OC8051_IFETCH_EA_CHECK_EN
    , ST_FAULT = 2'd3
`endif
  } state_e;

  state_e      state;
  logic [15:0] pc;
  logic        ins_valid;
  logic [7:0]  ins_op;
  logic [7:0]  ins_op1;
  logic [7:0]  ins_op2;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;

  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    casez (op)
      8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75, 8'h85,
      8'h90, 8'b1011_01??, 8'b1011_1???, 8'hD5:
        len = 2'd3;
      8'b????_0001:
        len = 2'd2;
      8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42, 8'h44, 8'h45,
      8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72,
      8'h74, 8'b0111_011?, 8'b0111_1???, 8'h80, 8'h82, 8'b1000_011?,
      8'b1000_1???, 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2, 8'b1010_011?,
      8'b1010_1???, 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2,
      8'b1101_1???, 8'hE5, 8'hF5:
        len = 2'd2;
      default:
        len = 2'd1;
    endcase
    return len;
  endfunction

`ifdef OC8051_IFETCH_EA_CHECK_EN
  logic ea_q;
  logic fault_q;
  assign ext_fault = fault_q;
`else
  logic unused_ea_int;
  assign unused_ea_int = bus.ea_int;
  assign ext_fault     = 1'b0;
`endif

  // pc_load outranks everything, including a simultaneous handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FETCH;
      pc        <= RST_PC;
      ins_valid <= 1'b0;
      ins_op    <= 8'h00;
      ins_op1   <= 8'h00;
      ins_op2   <= 8'h00;
      ins_len   <= 2'd1;
      ins_pc    <= RST_PC;
`ifdef OC8051_IFETCH_EA_CHECK_EN
      ea_q      <= 1'b1;
      fault_q   <= 1'b0;
`endif
    end else if (pc_load) begin
      state     <= ST_FETCH;
      pc        <= pc_in;
      ins_valid <= 1'b0;
`ifdef OC8051_IFETCH_EA_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
`ifdef OC8051_IFETCH_EA_CHECK_EN
          ea_q  <= bus.ea_int;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          ins_op  <= bus.rom_data1;
          ins_op1 <= bus.rom_data2;
          ins_op2 <= bus.rom_data3;
          ins_len <= decode_len(bus.rom_data1);
          ins_pc  <= pc;
`ifdef OC8051_IFETCH_EA_CHECK_EN
          if (!ea_q) begin
            state   <= ST_FAULT;
            fault_q <= 1'b1;
          end else begin
            state     <= ST_VALID;
            ins_valid <= 1'b1;
          end
`else
          state     <= ST_VALID;
          ins_valid <= 1'b1;
`endif
        end
        ST_VALID: begin
          if (bus.ins_ready) begin
            pc        <= pc + {14'd0, ins_len};
            ins_valid <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        default: begin
          // Fault parks here until a redirect or reset.
          state <= state;
        end
      endcase
    end
  end

  // The ROM address register is the PC register itself.
  assign bus.rom_addr  = pc;
  assign bus.ins_valid = ins_valid;
  assign bus.ins_op    = ins_op;
  assign bus.ins_op1   = ins_op1;
  assign bus.ins_op2   = ins_op2;
  assign bus.ins_len   = ins_len;
  assign bus.ins_pc    = ins_pc;
  assign dbg_state     = state;

endmodule

// File: tb/tb_oc8051_ifetch.sv
// Directed bench for oc8051_ifetch: ROM model, hand-computed instruction checks.
module tb_oc8051_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        ext_fault;
  logic [1:0]  dbg_state;

  oc8051_ifetch_if bus ();

  oc8051_ifetch #(.RST_PC(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_load   (pc_load),
    .bus       (bus.master),
    .ext_fault (ext_fault),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Program ROM: registered three-byte window, addresses wrap at 64K.
  logic [7:0]  mem [0:65535];
  logic [15:0] a1, a2;
  assign a1 = bus.rom_addr + 16'd1;
  assign a2 = bus.rom_addr + 16'd2;
  always @(posedge clk) begin
    bus.rom_data1 <= mem[bus.rom_addr];
    bus.rom_data2 <= mem[a1];
    bus.rom_data3 <= mem[a2];
  end
  assign bus.ea_int = (bus.rom_addr != 16'h0100);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept();
    bus.ins_ready = 1'b1;
    tick(1);
    bus.ins_ready = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] target);
    pc_load = 1'b1;
    pc_in   = target;
    tick(1);
    pc_load = 1'b0;
  endtask

  task automatic check_ins(input string tag, input logic [7:0] op, input logic [7:0] op1,
                           input logic [7:0] op2, input logic [1:0] len, input logic [15:0] pc);
    check({tag, ".valid"}, bus.ins_valid, 1);
    check({tag, ".op"},    bus.ins_op,    op);
    check({tag, ".op1"},   bus.ins_op1,   op1);
    check({tag, ".op2"},   bus.ins_op2,   op2);
    check({tag, ".len"},   bus.ins_len,   len);
    check({tag, ".pc"},    bus.ins_pc,    pc);
  endtask

  // Length decode spot vectors: opcode, expected length.
  logic [7:0] len_op  [15] = '{8'hA4, 8'h84, 8'hA5, 8'h73, 8'hB4, 8'hBF, 8'hD5, 8'hE1,
                              8'hD8, 8'h7F, 8'h76, 8'hC5, 8'h90, 8'h86, 8'h04};
  logic [1:0] len_exp [15] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd2,
                              2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1};

  initial begin
    bus.ins_ready = 1'b0;
    pc_load = 1'b0;
    pc_in   = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h02; mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h5B;
    mem[16'h0003] = 8'h75; mem[16'h0004] = 8'h08; mem[16'h0005] = 8'h00;
    mem[16'h0006] = 8'hE4;
    mem[16'h0007] = 8'h8D; mem[16'h0008] = 8'hF0;
    mem[16'h0067] = 8'hEF;
    mem[16'h0069] = 8'h8D; mem[16'h006A] = 8'hF0;
    mem[16'hFFFF] = 8'h12;
    for (int i = 0; i < 15; i++) mem[16'h0200 + 16'(i * 4)] = len_op[i];

    // Reset values
    #12;
    check("rst.rom_addr", bus.rom_addr, 16'h0000);
    check("rst.valid",    bus.ins_valid, 0);
    check("rst.op",       bus.ins_op, 8'h00);
    check("rst.len",      bus.ins_len, 2'd1);
    check("rst.pc",       bus.ins_pc, 16'h0000);
    check("rst.fault",    ext_fault, 0);
    check("rst.state",    dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    // Two-cycle latency to the first instruction
    tick(1);
    check("lat.valid_c1", bus.ins_valid, 0);
    tick(1);
    check_ins("i0000", 8'h02, 8'h00, 8'h5B, 2'd3, 16'h0000);

    accept();
    check("acc0.valid", bus.ins_valid, 0);
    check("acc0.rom_addr", bus.rom_addr, 16'h0003);
    tick(2);
    check_ins("i0003", 8'h75, 8'h08, 8'h00, 2'd3, 16'h0003);
    accept();
    tick(2);
    check_ins("i0006", 8'hE4, 8'h8D, 8'hF0, 2'd1, 16'h0006);
    accept();
    check("acc2.rom_addr", bus.rom_addr, 16'h0007);
    tick(2);

    // Stall: payload must hold for five cycles
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_ins("stall", 8'h8D, 8'hF0, 8'h00, 2'd2, 16'h0007);
      check("stall.rom_addr", bus.rom_addr, 16'h0007);
    end
    accept();
    check("stall.adv", bus.rom_addr, 16'h0009);
    tick(1);
    check("stall.one_adv", bus.rom_addr, 16'h0009);
    check("wait.state", dbg_state, 2'd1);

    // Redirect while in WAIT drops the in-flight fetch
    redirect(16'h0067);
    check("rd_wait.valid", bus.ins_valid, 0);
    check("rd_wait.rom_addr", bus.rom_addr, 16'h0067);
    check("rd_wait.state", dbg_state, 2'd0);
    tick(1);
    check("rd_wait.valid2", bus.ins_valid, 0);
    tick(1);
    check_ins("i0067", 8'hEF, 8'h00, 8'h8D, 2'd1, 16'h0067);
    accept();
    tick(2);
    check_ins("i0068", 8'h00, 8'h8D, 8'hF0, 2'd1, 16'h0068);
    accept();
    tick(2);
    check_ins("i0069", 8'h8D, 8'hF0, 8'h00, 2'd2, 16'h0069);

    // Redirect coinciding with a handshake: pc takes pc_in
    bus.ins_ready = 1'b1;
    redirect(16'hFFFF);
    bus.ins_ready = 1'b0;
    check("rd_hs.valid", bus.ins_valid, 0);
    check("rd_hs.rom_addr", bus.rom_addr, 16'hFFFF);
    tick(2);
    check_ins("iFFFF", 8'h12, 8'h02, 8'h00, 2'd3, 16'hFFFF);
    accept();
    check("wrap.rom_addr", bus.rom_addr, 16'h0002);
    tick(2);
    check_ins("i0002", 8'h5B, 8'h75, 8'h08, 2'd1, 16'h0002);

    // Asynchronous reset in VALID
    #2 rst = 1'b0;
    #1;
    check("arst.valid", bus.ins_valid, 0);
    check("arst.rom_addr", bus.rom_addr, 16'h0000);
    check("arst.pc", bus.ins_pc, 16'h0000);
    check("arst.state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    // Length decode spot checks
    for (int i = 0; i < 15; i++) begin
      redirect(16'h0200 + 16'(i * 4));
      tick(2);
      check($sformatf("len_%02h", len_op[i]), bus.ins_len, len_exp[i]);
      check($sformatf("lenpc_%02h", len_op[i]), bus.ins_pc, 16'h0200 + 16'(i * 4));
    end

    // Fetch outside internal ROM
    redirect(16'h0100);
    tick(2);
`ifdef OC8051_IFETCH_EA_CHECK_EN
    check("ea.fault", ext_fault, 1);
    check("ea.valid", bus.ins_valid, 0);
    check("ea.state", dbg_state, 2'd3);
    tick(3);
    check("ea.fault_hold", ext_fault, 1);
    check("ea.valid_hold", bus.ins_valid, 0);
`else
    check("ea.fault", ext_fault, 0);
    check("ea.valid", bus.ins_valid, 1);
    check("ea.pc", bus.ins_pc, 16'h0100);
    tick(3);
    check("ea.fault_hold", ext_fault, 0);
`endif
    redirect(16'h0000);
    check("ea.clear", ext_fault, 0);
    tick(2);
    check_ins("ea.resume", 8'h02, 8'h00, 8'h5B, 2'd3, 16'h0000);
    check("ea.fault_end", ext_fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
